// File: rtl/sprite_mem_pkg.sv
// sprite_mem_pkg: shared types and default sizing for the sprite RAM arbiter.
package sprite_mem_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_HOST} owner_t;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    localparam int DEF_DEPTH = 49152;
    localparam int DEF_STARVE_LIMIT = 8;
endpackage

// File: rtl/mem_ret_pipe.sv
// mem_ret_pipe: two-stage owner tag that steers registered RAM read data to its requester.
module mem_ret_pipe
    import sprite_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag,
    output logic   disp_valid,
    output logic   host_rvalid
);
    owner_t s1, s2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= OWN_NONE;
            s2 <= OWN_NONE;
        end else begin
            s1 <= tag;
            s2 <= s1;
        end
    end
    assign disp_valid  = s2 == OWN_DISP;
    assign host_rvalid = s2 == OWN_HOST;
endmodule

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter: shares one sprite RAM port between display fetch and host,
// with a starvation guard for the host and a bulk-clear fill sequencer.
module sprite_mem_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ready,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_val;
    logic              avail, host_force, disp_grant, host_grant;
    owner_t            tag;

    assign avail      = state == ST_IDLE && !clear_start && !rst;
    assign host_force = host_req && starve_cnt == SLIM;
    assign disp_ready = avail && !host_force;
    assign host_ready = avail && (host_force || !disp_req);
    assign disp_grant = disp_req && disp_ready;
    assign host_grant = host_req && host_ready;
    assign tag        = disp_grant ? OWN_DISP : (host_grant && !host_we) ? OWN_HOST : OWN_NONE;
    assign clear_busy = state == ST_CLEAR;
    assign disp_data  = ram_rdata;
    assign host_rdata = ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            clr_addr   <= '0;
            clr_val    <= '0;
            clear_done <= 1'b0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_raddr  <= '0;
            ram_wdata  <= '0;
        end else begin
            clear_done <= 1'b0;
            ram_we     <= 1'b0;
            starve_cnt <= (!host_req || host_grant) ? '0 : (starve_cnt == SLIM) ? starve_cnt : starve_cnt + 1'b1;
            if (state == ST_CLEAR) begin
                ram_we    <= 1'b1;
                ram_waddr <= clr_addr;
                ram_wdata <= clr_val;
                if (clr_addr == LAST) begin
                    state      <= ST_IDLE;
                    clear_done <= 1'b1;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
            end else if (clear_start) begin
                clr_val  <= clear_value;
                clr_addr <= '0;
                state    <= ST_CLEAR;
            end else if (host_grant && host_we) begin
                ram_we    <= 1'b1;
                ram_waddr <= host_addr;
                ram_wdata <= host_wdata;
            end
            if (disp_grant) ram_raddr <= disp_addr;
            else if (host_grant && !host_we) ram_raddr <= host_addr;
        end
    end

    mem_ret_pipe u_ret (
        .clk        (clk),
        .rst        (rst),
        .tag        (tag),
        .disp_valid (disp_valid),
        .host_rvalid(host_rvalid)
    );
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb_sprite_mem_arbiter: scenario tasks plus a scoreboard of expected read returns,
// checked against a behavioural one-cycle registered RAM.
module tb_sprite_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        disp_req = 0, host_req = 0, host_we = 0, clear_start = 0;
    logic [19:0] disp_addr = 0, host_addr = 0;
    logic [7:0]  host_wdata = 0, clear_value = 0;
    logic        disp_ready, disp_valid, host_ready, host_rvalid, clear_busy, clear_done, ram_we;
    logic [7:0]  disp_data, host_rdata, ram_wdata, ram_rdata;
    logic [19:0] ram_waddr, ram_raddr;

    typedef struct packed {int due; logic [7:0] data;} exp_t;
    exp_t dq[$], hq[$];
    exp_t e;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] mem [0:1023];

    sprite_mem_arbiter #(.ADDR_W(20), .DATA_W(8), .DEPTH(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ready(disp_ready),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 16);
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr[9:0]] <= ram_wdata;
        ram_rdata <= mem[ram_raddr[9:0]];
    end

    always @(negedge clk) begin
        if (disp_valid) begin
            n_cmp++;
            if (dq.size() == 0) begin
                n_bad++;
                $display("FAIL disp_unexpected: valid at cycle %0d data %0h, required no valid", cyc, disp_data);
            end else begin
                e = dq.pop_front();
                if (e.due !== cyc || disp_data !== e.data) begin
                    n_bad++;
                    $display("FAIL disp_return: cycle %0d data %0h, required cycle %0d data %0h", cyc, disp_data, e.due, e.data);
                end
            end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
            n_cmp++; n_bad++;
            e = dq.pop_front();
            $display("FAIL disp_missing: no valid at cycle %0d, required data %0h", cyc, e.data);
        end
        if (host_rvalid) begin
            n_cmp++;
            if (hq.size() == 0) begin
                n_bad++;
                $display("FAIL host_unexpected: rvalid at cycle %0d data %0h, required no rvalid", cyc, host_rdata);
            end else begin
                e = hq.pop_front();
                if (e.due !== cyc || host_rdata !== e.data) begin
                    n_bad++;
                    $display("FAIL host_return: cycle %0d data %0h, required cycle %0d data %0h", cyc, host_rdata, e.due, e.data);
                end
            end
        end else if (hq.size() > 0 && hq[0].due <= cyc) begin
            n_cmp++; n_bad++;
            e = hq.pop_front();
            $display("FAIL host_missing: no rvalid at cycle %0d, required data %0h", cyc, e.data);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        disp_req = 1; host_req = 1;
        tick(3);
        n_cmp++;
        if ({disp_ready, host_ready, ram_we, disp_valid, host_rvalid, clear_busy, clear_done} !== 7'b0 ||
            ram_waddr !== 0 || ram_raddr !== 0 || ram_wdata !== 0) begin
            n_bad++;
            $display("FAIL reset_state: rdy %b%b we %b val %b%b busy %b done %b wa %0h ra %0h wd %0h, required all 0",
                     disp_ready, host_ready, ram_we, disp_valid, host_rvalid, clear_busy, clear_done, ram_waddr, ram_raddr, ram_wdata);
        end
        disp_req = 0; host_req = 0;
        rst = 0;
        tick();
    endtask

    task automatic test_disp_burst();
        disp_req = 1;
        for (int i = 0; i < 4; i++) begin
            disp_addr = 20'(i);
            #1;
            n_cmp++;
            if (disp_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL disp_burst_ready: beat %0d ready %b, required 1", i, disp_ready);
            end else dq.push_back('{cyc + 2, 8'(i + 16)});
            tick();
        end
        disp_req = 0;
        tick(4);
    endtask

    task automatic test_host_rw();
        host_req = 1; host_we = 1; host_addr = 100; host_wdata = 8'hA5;
        #1;
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL host_wr_ready: ready %b, required 1", host_ready);
        end
        tick();
        n_cmp++;
        if (ram_we !== 1'b1 || ram_waddr !== 20'd100 || ram_wdata !== 8'hA5) begin
            n_bad++;
            $display("FAIL host_wr_ram: we %b addr %0d data %0h, required 1 100 a5", ram_we, ram_waddr, ram_wdata);
        end
        host_we = 0;
        #1;
        if (host_ready === 1'b1) hq.push_back('{cyc + 2, 8'hA5});
        tick();
        host_req = 0;
        n_cmp++;
        if (ram_we !== 1'b0 || ram_raddr !== 20'd100) begin
            n_bad++;
            $display("FAIL host_rd_ram: we %b raddr %0d, required 0 100", ram_we, ram_raddr);
        end
        tick(4);
    endtask

    task automatic test_starve();
        disp_req = 1; host_req = 1; host_we = 0; disp_addr = 5; host_addr = 7;
        for (int k = 0; k < 18; k++) begin
            #1;
            n_cmp++;
            if (disp_ready !== (k % 9 != 8) || host_ready !== (k % 9 == 8)) begin
                n_bad++;
                $display("FAIL starve_grant: cycle %0d disp_ready %b host_ready %b, required %b %b",
                         k, disp_ready, host_ready, k % 9 != 8, k % 9 == 8);
            end
            if (disp_ready) dq.push_back('{cyc + 2, 8'd21});
            else if (host_ready) hq.push_back('{cyc + 2, 8'd23});
            tick();
        end
        disp_req = 0; host_req = 0;
        tick(4);
    endtask

    task automatic test_clear();
        clear_value = 8'h3C; clear_start = 1;
        #1;
        n_cmp++;
        if (disp_ready !== 1'b0 || host_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_start_ready: %b %b, required 0 0", disp_ready, host_ready);
        end
        tick();
        clear_start = 0; clear_value = 8'h00;
        for (int j = 0; j < 16; j++) begin
            n_cmp++;
            if (clear_busy !== 1'b1 || clear_done !== 1'b0 || disp_ready !== 1'b0 || host_ready !== 1'b0 ||
                (j > 0 && (ram_we !== 1'b1 || ram_waddr !== 20'(j - 1) || ram_wdata !== 8'h3C))) begin
                n_bad++;
                $display("FAIL clear_cycle: j %0d busy %b done %b rdy %b%b we %b wa %0d wd %0h, required busy 1 addr %0d 3c",
                         j, clear_busy, clear_done, disp_ready, host_ready, ram_we, ram_waddr, ram_wdata, j - 1);
            end
            tick();
        end
        n_cmp++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 20'd15) begin
            n_bad++;
            $display("FAIL clear_end: busy %b done %b we %b wa %0d, required 0 1 1 15", clear_busy, clear_done, ram_we, ram_waddr);
        end
        tick();
        n_cmp++;
        if (clear_done !== 1'b0 || ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_done_pulse: done %b we %b, required 0 0", clear_done, ram_we);
        end
        disp_req = 1;
        for (int i = 0; i < 3; i++) begin
            disp_addr = (i == 0) ? 20'd0 : (i == 1) ? 20'd15 : 20'd16;
            #1;
            if (disp_ready) dq.push_back('{cyc + 2, (i == 2) ? 8'd32 : 8'h3C});
            tick();
        end
        disp_req = 0;
        tick(4);
    endtask

    task automatic test_clear_host();
        host_req = 1; host_we = 0; host_addr = 200; clear_start = 1; clear_value = 8'h11;
        #1;
        n_cmp++;
        if (host_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_host_ready: ready %b with clear_start, required 0", host_ready);
        end
        tick();
        clear_start = 0;
        for (int j = 0; j < 16; j++) begin
            n_cmp++;
            if (host_ready !== 1'b0 || clear_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL clear_host_hold: j %0d ready %b busy %b, required 0 1", j, host_ready, clear_busy);
            end
            tick();
        end
        n_cmp++;
        if (clear_done !== 1'b1 || host_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_host_post: done %b ready %b, required 1 1", clear_done, host_ready);
        end else hq.push_back('{cyc + 2, 8'd216});
        tick();
        host_req = 0;
        tick(4);
    endtask

    task automatic test_reset_mid();
        logic bad;
        disp_req = 1; disp_addr = 3;
        #1;
        if (disp_ready) dq.push_back('{cyc + 2, 8'd19});
        tick();
        disp_req = 0;
        #2 rst = 1;
        dq.delete();
        #1;
        n_cmp++;
        if (disp_valid !== 1'b0 || ram_raddr !== 0) begin
            n_bad++;
            $display("FAIL reset_inflight: valid %b raddr %0d, required 0 0", disp_valid, ram_raddr);
        end
        tick(2);
        rst = 0;
        tick();
        clear_value = 8'h77; clear_start = 1;
        tick();
        clear_start = 0;
        tick(5);
        #1 rst = 1;
        #1;
        n_cmp++;
        if ({ram_we, clear_busy, clear_done, disp_valid, host_rvalid} !== 5'b0 || ram_waddr !== 0 || ram_wdata !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: we %b busy %b done %b wa %0d wd %0h, required all 0",
                     ram_we, clear_busy, clear_done, ram_waddr, ram_wdata);
        end
        tick(2);
        rst = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (clear_done !== 1'b0 || clear_busy !== 1'b0 || ram_we !== 1'b0) bad = 1;
            tick();
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL reset_no_done: clear activity after reset, required idle");
        end
    endtask

    initial begin
        test_reset();
        test_disp_burst();
        test_host_rw();
        test_starve();
        test_clear();
        test_clear_host();
        test_reset_mid();
        tick(2);
        n_cmp++;
        if (dq.size() != 0 || hq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d disp %0d host outstanding, required 0 0", dq.size(), hq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_mem_arbiter.md
# sprite_mem_arbiter

Shares the single read/write port of a sprite frame RAM (8-bit data, 20-bit address, one-cycle registered read) between the VGA display fetch path and the game-logic host port. It also hosts a bulk-clear sequencer that fills the RAM with a constant value. The block sits between the sprite RAM instance and its two clients. It owns all RAM-side control signals.

## Interface
- ADDR_W, 20, RAM address width
- DATA_W, 8, RAM data width (palette index)
- DEPTH, 49152, number of RAM words touched by bulk clear
- STARVE_LIMIT, 8, consecutive denied host cycles before host is forced through
- Clk  in  1  single clock; all state on posedge
- Reset  in  1  asynchronous, active-high reset
- disp_req  in  1  display read request (valid)
- disp_addr  in  ADDR_W  display read address
- disp_ready  out  1  display request accepted this cycle when disp_req&disp_ready
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid this cycle
- host_req  in  1  host request (valid)
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ready  out  1  host request accepted when host_req&host_ready
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid this cycle (reads only)
- clear_start  in  1  start bulk clear (sampled in IDLE only)
- clear_value  in  DATA_W  fill value, sampled at clear_start accept
- clear_busy  out  1  bulk clear in progress
- clear_done  out  1  one-cycle pulse after last clear write
- ram_we, ram_waddr, ram_raddr, ram_wdata  out  1/ADDR_W/ADDR_W/DATA_W  registered RAM controls
- ram_rdata  in  DATA_W  RAM data_Out

## Operation
- FSM states: ST_IDLE (arbitrate), ST_CLEAR (sequential fill). Reset -> ST_IDLE.
- ST_IDLE arbitration happens every cycle. At most one request is accepted per cycle.
  - Host is forced when host_req and starve_cnt == STARVE_LIMIT.
  - Otherwise display wins if disp_req.
  - Otherwise host wins if host_req.
- disp_ready and host_ready are combinational from the arbitration result.
  - Both are 0 in ST_CLEAR.
  - Both are 0 while clear_start=1 in ST_IDLE.
  - Both are 0 while Reset=1.
- starve_cnt (saturating at STARVE_LIMIT):
  - +1 each cycle host_req=1 and host not accepted.
  - Cleared on host accept.
  - Cleared when host_req=0.
- Accepted read: ram_raddr is registered from the winner's address. A 2-stage owner tag (OWN_NONE/DISP/HOST) tracks the return.
  - The tag at stage 2 selects which valid fires.
  - ram_rdata drives disp_data and host_rdata directly.
- Accepted host write: ram_we=1, ram_waddr/ram_wdata registered for one cycle. No response.
- clear_start in ST_IDLE:
  - Latch clear_value, set clr_addr=0, go to ST_CLEAR.
- ST_CLEAR:
  - Each cycle registers ram_we=1, ram_waddr=clr_addr, ram_wdata=latched value, then clr_addr+1.
  - After the write of DEPTH-1: go to ST_IDLE, pulse clear_done.
  - clear_start is ignored in ST_CLEAR.
  - Reads accepted before the clear still complete normally.
- clear_busy = (state == ST_CLEAR).

## Timing
- Reset values: ram_we=0, ram addresses/wdata=0, disp_valid=host_rvalid=0, clear_busy=clear_done=0, starve_cnt=0, tags=OWN_NONE, clr_addr=0.
- Read latency: accept at edge E0 -> RAM samples at E1 -> valid high for exactly the cycle after E1 (2 cycles from accept).
- Throughput: one read per cycle sustained, with back-to-back grants pipelined.
- Write: ram_we high for exactly the cycle following the accept edge.
- Clear: ST_CLEAR lasts exactly DEPTH cycles. clear_done is high in the first ST_IDLE cycle. Requests can be accepted in that same cycle.
- Reset mid-clear: immediate return to ST_IDLE, no clear_done, in-flight tags dropped (no valid).
- clr_addr width is ADDR_W. Comparison is against DEPTH-1, with no wrap past DEPTH-1.

## Structure
- Package sprite_mem_pkg:
  - owner_t enum (OWN_NONE, OWN_DISP, OWN_HOST)
  - state_t enum (ST_IDLE, ST_CLEAR)
  - default DEPTH/STARVE_LIMIT constants
- One sub-module, mem_ret_pipe: a 2-stage owner-tag shift register with async reset. It outputs disp_valid and host_rvalid.

## Test plan
- Display only, disp_req held 4 cycles at addrs 0..3 (RAM preloaded mem[i]=i+16) -> disp_valid high 4 consecutive cycles starting 2 after first accept, data 16,17,18,19.
- Host write addr 100 data 0xA5, then host read addr 100 -> ram_we one cycle, host_rvalid 2 cycles after read accept with 0xA5.
- disp_req and host_req both held continuously, STARVE_LIMIT=8 -> host accepted on 9th cycle, disp_ready=0 that cycle only, pattern repeats every 9 cycles.
- clear_start with clear_value 0x3C, DEPTH=16 -> clear_busy 16 cycles, addrs 0..15 written 0x3C, clear_done one pulse, readies 0 throughout.
- Reset asserted at clear cycle 5 with a read in flight -> all outputs at reset values, no valid, no clear_done, FSM in ST_IDLE.
- clear_start and host_req in same ST_IDLE cycle -> host_ready=0, clear proceeds, host accepted in first post-clear cycle.
